// File: rtl/vector_mem_arbiter.sv
// vector_mem_arbiter: round-robin arbiter between the MEM-stage vector
// load/store unit (requester 0) and the host/debug loader (requester 1) for a
// single vector memory port. One request is served every three cycles:
// IDLE (accept) -> ACCESS (memory cycle) -> RESP (one-cycle response).
// Optional feature macro: VMEM_BOUNDS_CHECK_EN. When it is defined,
// out-of-range lane addresses flag an error. When it is undefined, lane
// addresses wrap modulo MEM_DEPTH.
//
// Handshake: a requester holds valid and its payload stable until it sees
// ready. ready is asserted combinationally only in IDLE, only for the winner.
// The request transfers on the rising edge where valid && ready are both high.
// rspN_valid is a single-cycle pulse and has no back-pressure.
module vector_mem_arbiter #(
  parameter int LANES     = 16,
  parameter int ELEM_W    = 16,
  parameter int DATA_W    = 256,
  parameter int ADDR_W    = 32,
  parameter int MEM_DEPTH = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req0_valid,
  output logic                      req0_ready,
  input  logic                      req0_we,
  input  logic [ADDR_W-1:0]         req0_base,
  input  logic [ADDR_W-1:0]         req0_stride,
  input  logic [DATA_W-1:0]         req0_wdata,
  output logic                      rsp0_valid,
  output logic [DATA_W-1:0]         rsp0_rdata,
  output logic                      rsp0_err,
  input  logic                      req1_valid,
  output logic                      req1_ready,
  input  logic                      req1_we,
  input  logic [ADDR_W-1:0]         req1_base,
  input  logic [ADDR_W-1:0]         req1_stride,
  input  logic [DATA_W-1:0]         req1_wdata,
  output logic                      rsp1_valid,
  output logic [DATA_W-1:0]         rsp1_rdata,
  output logic                      rsp1_err,
  output logic                      mem_wren,
  output logic [LANES*ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic [DATA_W-1:0]         mem_rdata,
  output logic [1:0]                dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t              state, state_n;
  logic                last;
  logic                win_id;
  logic                grant_any;
  logic                grant_id;
  logic                lat_we;
  logic [ADDR_W-1:0]   lat_base;
  logic [ADDR_W-1:0]   lat_stride;
  logic [DATA_W-1:0]   lat_wdata;
  logic [DATA_W-1:0]   rdata_q;
  logic                err_c;
  logic [ADDR_W-1:0]   lane_raw [LANES];

  // State register; reset drops any in-flight request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next state and round-robin grant: on a tie the requester that is not
  // 'last' wins, so requester 0 wins the first tie after reset.
  always_comb begin
    state_n    = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    grant_any  = 1'b0;
    grant_id   = 1'b0;
    case (state)
      IDLE: begin
        if (req0_valid && (!req1_valid || last)) begin
          req0_ready = 1'b1;
          grant_any  = 1'b1;
          grant_id   = 1'b0;
        end else if (req1_valid) begin
          req1_ready = 1'b1;
          grant_any  = 1'b1;
          grant_id   = 1'b1;
        end
        if (grant_any) state_n = ACCESS;
      end
      ACCESS:  state_n = RESP;
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Latch the winning request payload and update the arbitration history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last       <= 1'b1;
      win_id     <= 1'b0;
      lat_we     <= 1'b0;
      lat_base   <= '0;
      lat_stride <= '0;
      lat_wdata  <= '0;
    end else if (state == IDLE && grant_any) begin
      last       <= grant_id;
      win_id     <= grant_id;
      lat_we     <= grant_id ? req1_we     : req0_we;
      lat_base   <= grant_id ? req1_base   : req0_base;
      lat_stride <= grant_id ? req1_stride : req0_stride;
      lat_wdata  <= grant_id ? req1_wdata  : req0_wdata;
    end
  end

  // Per-lane element address, base + i*stride modulo 2^ADDR_W.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      lane_raw[i] = lat_base + ADDR_W'(i) * lat_stride;
    end
  end

`ifdef VMEM_BOUNDS_CHECK_EN
  logic rsp_err_q;

  // Any lane past the end of memory makes the whole request an error.
  always_comb begin
    err_c = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      if (lane_raw[i] >= ADDR_W'(MEM_DEPTH)) err_c = 1'b1;
    end
  end

  // Lane addresses go out unmodified during ACCESS, zero otherwise.
  always_comb begin
    mem_addr = '0;
    if (state == ACCESS) begin
      for (int i = 0; i < LANES; i++) begin
        mem_addr[i*ADDR_W +: ADDR_W] = lane_raw[i];
      end
    end
  end

  // Capture the error flag alongside the read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  rsp_err_q <= 1'b0;
    else if (state == ACCESS) rsp_err_q <= err_c;
  end

  assign rsp0_err = rsp0_valid & rsp_err_q;
  assign rsp1_err = rsp1_valid & rsp_err_q;
`else
  localparam int IDX_W = $clog2(MEM_DEPTH);
  logic unused_lane_bits;

  assign err_c = 1'b0;

  // Lane addresses wrap to the memory size; upper bits are forced to zero.
  always_comb begin
    mem_addr         = '0;
    unused_lane_bits = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      unused_lane_bits = unused_lane_bits ^ (^lane_raw[i][ADDR_W-1:IDX_W]);
      if (state == ACCESS) begin
        mem_addr[i*ADDR_W +: ADDR_W] = {{(ADDR_W-IDX_W){1'b0}}, lane_raw[i][IDX_W-1:0]};
      end
    end
  end

  assign rsp0_err = 1'b0;
  assign rsp1_err = 1'b0;
`endif

  // Register load data at the end of ACCESS; stores and errors return zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  rdata_q <= '0;
    else if (state == ACCESS) rdata_q <= (lat_we || err_c) ? '0 : mem_rdata;
  end

  assign mem_wren   = (state == ACCESS) && lat_we && !err_c;
  assign mem_wdata  = (state == ACCESS) ? lat_wdata : '0;
  assign rsp0_valid = (state == RESP) && (win_id == 1'b0);
  assign rsp1_valid = (state == RESP) && (win_id == 1'b1);
  assign rsp0_rdata = (win_id == 1'b0) ? rdata_q : '0;
  assign rsp1_rdata = (win_id == 1'b1) ? rdata_q : '0;
  assign dbg_state  = state;

endmodule

// File: tb/tb_vector_mem_arbiter.sv
// Directed testbench for vector_mem_arbiter with a behavioural 32-element
// vector memory.
module tb_vector_mem_arbiter;

`ifdef VMEM_BOUNDS_CHECK_EN
  localparam bit BC = 1'b1;
`else
  localparam bit BC = 1'b0;
`endif

  logic         clk, rst;
  logic         req0_valid, req0_ready, req0_we;
  logic [31:0]  req0_base, req0_stride;
  logic [255:0] req0_wdata, rsp0_rdata;
  logic         rsp0_valid, rsp0_err;
  logic         req1_valid, req1_ready, req1_we;
  logic [31:0]  req1_base, req1_stride;
  logic [255:0] req1_wdata, rsp1_rdata;
  logic         rsp1_valid, rsp1_err;
  logic         mem_wren;
  logic [511:0] mem_addr;
  logic [255:0] mem_wdata, mem_rdata;
  logic [1:0]   dbg_state;

  logic [15:0]  mem [32];
  logic         tb_init;
  logic [511:0] acc_addr;
  int           total, bad;

  vector_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
    .req0_base(req0_base), .req0_stride(req0_stride), .req0_wdata(req0_wdata),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
    .req1_base(req1_base), .req1_stride(req1_stride), .req1_wdata(req1_wdata),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
    .mem_wren(mem_wren), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .dbg_state(dbg_state)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Vector memory: lanes written in order, so the highest aliased lane wins.
  always @(posedge clk) begin
    if (tb_init) begin
      for (int i = 0; i < 32; i++) mem[i] <= 16'h0100 + 16'(i);
    end else if (mem_wren) begin
      for (int i = 0; i < 16; i++) begin
        if (mem_addr[32*i+5 +: 27] == 27'd0) mem[mem_addr[32*i +: 5]] <= mem_wdata[16*i +: 16];
      end
    end
  end

  always_comb begin
    mem_rdata = '0;
    for (int i = 0; i < 16; i++) begin
      if (mem_addr[32*i+5 +: 27] == 27'd0) mem_rdata[16*i +: 16] = mem[mem_addr[32*i +: 5]];
    end
  end

  function automatic logic [255:0] ramp(input logic [15:0] b);
    logic [255:0] v;
    for (int i = 0; i < 16; i++) v[16*i +: 16] = b + 16'(i);
    return v;
  endfunction

  function automatic logic [255:0] splat(input logic [15:0] b);
    logic [255:0] v;
    for (int i = 0; i < 16; i++) v[16*i +: 16] = b;
    return v;
  endfunction

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drive one request and check the accept, ACCESS and RESP cycles.
  task automatic send(input string tag, input bit id, input logic we,
                      input logic [31:0] base, input logic [31:0] stride,
                      input logic [255:0] wdata, input logic exp_wren,
                      input logic [255:0] exp_rdata, input logic exp_err);
    logic rdy;
    @(negedge clk);
    if (id == 1'b0) begin
      req0_valid = 1'b1; req0_we = we; req0_base = base; req0_stride = stride; req0_wdata = wdata;
    end else begin
      req1_valid = 1'b1; req1_we = we; req1_base = base; req1_stride = stride; req1_wdata = wdata;
    end
    rdy = 1'b0;
    for (int k = 0; k < 10; k++) begin
      #1;
      rdy = id ? req1_ready : req0_ready;
      if (rdy) break;
      @(negedge clk);
    end
    check({tag, "_ready"}, rdy, 1'b1);
    check({tag, "_other_ready"}, id ? req0_ready : req1_ready, 1'b0);
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    check({tag, "_access_state"}, dbg_state, 2'd1);
    check({tag, "_wren"}, mem_wren, exp_wren);
    acc_addr = mem_addr;
    @(negedge clk);
    check({tag, "_rsp_valid"}, id ? rsp1_valid : rsp0_valid, 1'b1);
    check({tag, "_other_rsp_valid"}, id ? rsp0_valid : rsp1_valid, 1'b0);
    check({tag, "_rdata"}, id ? rsp1_rdata : rsp0_rdata, exp_rdata);
    check({tag, "_err"}, id ? rsp1_err : rsp0_err, exp_err);
    check({tag, "_wren_resp"}, mem_wren, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0; bad = 0;
    rst = 1'b1; tb_init = 1'b1;
    req0_valid = 0; req0_we = 0; req0_base = 0; req0_stride = 0; req0_wdata = 0;
    req1_valid = 0; req1_we = 0; req1_base = 0; req1_stride = 0; req1_wdata = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    // Reset values
    check("rst_state", dbg_state, 2'd0);
    check("rst_rsp_valid", {rsp0_valid, rsp1_valid, rsp0_err, rsp1_err}, 4'd0);
    check("rst_wren", mem_wren, 1'b0);
    check("rst_mem_addr", mem_addr, 512'd0);
    check("rst_mem_wdata", mem_wdata, 256'd0);
    check("rst_rdata", {rsp0_rdata, rsp1_rdata}, 512'd0);
    rst = 1'b0; tb_init = 1'b0;

    // Reset asserted during the ACCESS cycle of a store
    @(negedge clk);
    req0_valid = 1'b1; req0_we = 1'b1; req0_base = 0; req0_stride = 1; req0_wdata = splat(16'hFFFF);
    #1 check("rma_ready", req0_ready, 1'b1);
    @(posedge clk);
    #1 req0_valid = 1'b0;
    @(negedge clk);
    check("rma_wren_before", mem_wren, 1'b1);
    rst = 1'b1;
    #1;
    check("rma_state", dbg_state, 2'd0);
    check("rma_wren", mem_wren, 1'b0);
    check("rma_addr", mem_addr, 512'd0);
    check("rma_wdata", mem_wdata, 256'd0);
    @(posedge clk);
    @(negedge clk);
    check("rma_mem0", mem[0], 16'h0100);
    check("rma_mem15", mem[15], 16'h010F);
    check("rma_no_rsp", {rsp0_valid, rsp1_valid}, 2'd0);
    rst = 1'b0;

    // Simple load served normally after reset
    send("load0", 1'b0, 1'b0, 32'd0, 32'd1, 256'd0, 1'b0, ramp(16'h0100), 1'b0);
    check("load0_lane5_addr", acc_addr[32*5 +: 32], 32'd5);

    // Strided store then load back
    send("st1", 1'b1, 1'b1, 32'd1, 32'd2, ramp(16'hA000), 1'b1, 256'd0, 1'b0);
    check("st1_lane15_addr", acc_addr[32*15 +: 32], 32'd31);
    check("st1_mem1", mem[1], 16'hA000);
    check("st1_mem31", mem[31], 16'hA00F);
    check("st1_mem2", mem[2], 16'h0102);
    send("ld1", 1'b1, 1'b0, 32'd1, 32'd2, 256'd0, 1'b0, ramp(16'hA000), 1'b0);

    // Stride 0: all lanes alias element 5, highest lane wins
    send("alias_st", 1'b1, 1'b1, 32'd5, 32'd0, ramp(16'hC000), 1'b1, 256'd0, 1'b0);
    check("alias_mem5", mem[5], 16'hC00F);
    send("alias_ld", 1'b1, 1'b0, 32'd5, 32'd0, 256'd0, 1'b0, splat(16'hC00F), 1'b0);

    // Store running past the end of memory
    send("bnd", 1'b0, 1'b1, 32'd20, 32'd1, ramp(16'hB000), !BC, 256'd0, BC);
    check("bnd_lane12_addr", acc_addr[32*12 +: 32], BC ? 32'd32 : 32'd0);
    check("bnd_mem20", mem[20], BC ? 16'h0114 : 16'hB000);
    check("bnd_mem31", mem[31], BC ? 16'hA00F : 16'hB00B);
    check("bnd_mem0", mem[0], BC ? 16'h0100 : 16'hB00C);
    check("bnd_mem3", mem[3], BC ? 16'hA001 : 16'hB00F);

    // Round-robin tie held continuously from reset
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    req0_valid = 1'b1; req0_we = 1'b0; req0_base = 0; req0_stride = 1;
    req1_valid = 1'b1; req1_we = 1'b0; req1_base = 1; req1_stride = 2;
    for (int c = 0; c < 12; c++) begin
      #1;
      check($sformatf("rr_ready0_c%0d", c), req0_ready, (c % 6) == 0);
      check($sformatf("rr_ready1_c%0d", c), req1_ready, (c % 6) == 3);
      check($sformatf("rr_rsp0_c%0d", c), rsp0_valid, (c % 6) == 2);
      check($sformatf("rr_rsp1_c%0d", c), rsp1_valid, (c % 6) == 5);
      @(negedge clk);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rr_idle_end", dbg_state, 2'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
